qla_episode_controller: RTL and testbench
=========================================

Name: qla_episode_controller

Overview:
- Agent-side controller that sits directly upstream of the QLA core.
- Runs Q-learning episodes on the 5x5 grid (states 1..25):
  - reads the Q row of the current state;
  - picks an action epsilon-greedily with an internal LFSR;
  - computes next_state and step;
  - pulses decoder_en so QLA performs one Q update, then advances.
- Replaces the hand-driven current_state/next_state/act/step/decoder_en stimulus with autonomous episode sequencing.

Parameters:
- START_STATE, 1: episode start state.
- GOAL_STATE, 25: terminal state.
- MAX_STEP, 15: step limit per episode (step is 4-bit).
- EPSILON, 26: 8-bit explore threshold; explore when lfsr[7:0] < EPSILON (26 ≈ 10%).
- NUM_EPISODES, 100: episodes to run before DONE.
- UPDATE_LAT, 2: cycles QLA needs after the decoder_en pulse.
- LFSR_SEED, 16'hACE1: nonzero reset value of the 16-bit Fibonacci LFSR (taps 16,14,13,11).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low (0 = reset).
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- q_valid  in  1  Q row for current_state is valid this cycle.
- q_in_0..q_in_3  in  32 each  signed Q(current_state, a) for a = 0..3.
- current_state  out  5  state presented to QLA.
- next_state  out  5  state after the chosen action.
- act  out  2  chosen action.
- step  out  4  step index within the episode, 1-based while stepping.
- decoder_en  out  1  one-cycle Q-update strobe to QLA.
- episode_done  out  1  one-cycle pulse at episode end.
- episode_count  out  16  completed episodes.
- busy  out  1  high in every state except IDLE and DONE.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - FSM=IDLE, current_state=START_STATE, next_state=START_STATE;
  - act=0, step=0, decoder_en=0, episode_done=0, episode_count=0, busy=0;
  - lfsr=LFSR_SEED.
- Reset mid-operation aborts immediately; decoder_en falls in the same instant.
- The LFSR shifts every cycle while busy.
- FSM transitions:
  - IDLE: start → FETCH. start outside IDLE/DONE is ignored.
  - FETCH: hold current_state. On q_valid, register q_in_0..3 → SELECT. Otherwise wait indefinitely.
  - SELECT (1 cycle):
    - explore if lfsr[7:0] < EPSILON: act = lfsr[9:8];
    - else act = signed argmax of the four Q values; ties go to the lowest index;
    - → MOVE.
  - MOVE (1 cycle):
    - row = (s-1)/5, col = (s-1)%5;
    - act 00 = down (+5), 01 = right (+1), 10 = up (-5), 11 = left (-1);
    - a move off the grid leaves next_state = current_state;
    - step <= step+1; decoder_en=1 for exactly this cycle → UPDATE_WAIT.
  - UPDATE_WAIT: count UPDATE_LAT cycles → ADVANCE.
  - ADVANCE (1 cycle):
    - if next_state == GOAL_STATE or step == MAX_STEP: pulse episode_done, increment episode_count, set current_state=START_STATE and step=0;
    - otherwise current_state <= next_state;
    - then → DONE if episode_count (post-increment) == NUM_EPISODES, else → FETCH.
    - Goal and step limit on the same step count as one episode end.
  - DONE: busy=0, outputs held. start clears episode_count and step → FETCH.
- episode_count saturates at 16'hFFFF.
- Latency:
  - FETCH (with q_valid) → decoder_en is 2 cycles;
  - a full step is 4+UPDATE_LAT cycles when q_valid arrives immediately.

Optional Feature:
- Macro QLA_EPSILON_DECAY_EN.
- When defined: a live 8-bit epsilon register
  - resets to EPSILON;
  - decrements by 1 at each episode_done, floors at 0;
  - reloads to EPSILON on start from DONE.
- When undefined: the threshold is the constant EPSILON, and no register is built.

Decomposition:
- Shared package qla_pkg:
  - grid constants: GRID_W=5, NUM_STATES=25, STATE_W=5, Q_W=32, ACT_W=2;
  - action encodings ACT_DOWN/RIGHT/UP/LEFT;
  - FSM state enum.
- One natural sub-module, qla_grid_step: combinational (state, act) → next_state including wall handling; the testbench can reuse it as a golden model.
- LFSR and argmax stay inline.

Test Plan:
- Reset: hold rst=0 → current_state=1, step=0, act=0, decoder_en=0, busy=0, episode_count=0. Release and pulse start → FETCH, busy=1.
- Greedy tie (EPSILON=0): state 1, q_in = {5,10,-3,10}, q_valid=1 → act=01, next_state=2, step=1, decoder_en high exactly 1 cycle, 2 cycles after q_valid.
- Wall (EPSILON=0): current_state=5, Q favours act 01 → next_state=5. Current_state=1, Q favours act 10 → next_state=1.
- Goal: current_state=20, Q favours 00 → next_state=25, episode_done pulse, current_state=1, step=0, episode_count +1.
- Step limit (MAX_STEP=15): Q always favours 10 from state 1 → 15 decoder_en pulses, then episode_done with step==15. NUM_EPISODES=2 → DONE, busy=0.
- Reset mid-run: drop rst during UPDATE_WAIT → decoder_en=0 and all outputs at reset values immediately. With QLA_EPSILON_DECAY_EN, EPSILON=2: epsilon 2→1→0→0 over three episodes.

Source files
------------

// File: rtl/qla_pkg.sv
// Shared grid geometry, action encodings and episode FSM states for the QLA agent side.
// Purely declarative; no logic.
package qla_pkg;
  localparam int GRID_W     = 5;
  localparam int NUM_STATES = 25;
  localparam int STATE_W    = 5;
  localparam int Q_W        = 32;
  localparam int ACT_W      = 2;

  typedef enum logic [ACT_W-1:0] {
    ACT_DOWN  = 2'd0,
    ACT_RIGHT = 2'd1,
    ACT_UP    = 2'd2,
    ACT_LEFT  = 2'd3
  } act_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SELECT,
    ST_MOVE,
    ST_WAIT,
    ST_ADVANCE,
    ST_DONE
  } fsm_e;
endpackage

// File: rtl/qla_grid_step.sv
// Combinational 5x5 grid transition: (state, act) -> next state; off-grid moves stay put.
// Zero latency, no flow control.
module qla_grid_step
  import qla_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic [ACT_W-1:0]   act,
  output logic [STATE_W-1:0] next_state
);
  logic [STATE_W-1:0] idx;
  logic [2:0]         row;
  logic [2:0]         col;

  always_comb begin
    idx        = state - 5'd1;
    row        = 3'(idx / 5'(GRID_W));
    col        = 3'(idx % 5'(GRID_W));
    next_state = state;
    case (act)
      ACT_DOWN:  if (row != 3'(GRID_W - 1)) next_state = state + 5'(GRID_W);
      ACT_RIGHT: if (col != 3'(GRID_W - 1)) next_state = state + 5'd1;
      ACT_UP:    if (row != 3'd0)           next_state = state - 5'(GRID_W);
      default:   if (col != 3'd0)           next_state = state - 5'd1;
    endcase
  end
endmodule

// File: rtl/qla_episode_controller.sv
// Autonomous epsilon-greedy episode sequencer driving the QLA core; FETCH waits on q_valid, decoder_en 2 cycles later.
// Optional QLA_EPSILON_DECAY_EN builds a per-episode decaying epsilon register.
module qla_episode_controller
  import qla_pkg::*;
#(
  parameter logic [STATE_W-1:0] START_STATE  = 5'd1,
  parameter logic [STATE_W-1:0] GOAL_STATE   = 5'd25,
  parameter logic [3:0]         MAX_STEP     = 4'd15,
  parameter logic [7:0]         EPSILON      = 8'd26,
  parameter logic [15:0]        NUM_EPISODES = 16'd100,
  parameter int                 UPDATE_LAT   = 2,
  parameter logic [15:0]        LFSR_SEED    = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  q_valid,
  input  logic signed [Q_W-1:0] q_in_0,
  input  logic signed [Q_W-1:0] q_in_1,
  input  logic signed [Q_W-1:0] q_in_2,
  input  logic signed [Q_W-1:0] q_in_3,
  output logic [STATE_W-1:0]    current_state,
  output logic [STATE_W-1:0]    next_state,
  output logic [ACT_W-1:0]      act,
  output logic [3:0]            step,
  output logic                  decoder_en,
  output logic                  episode_done,
  output logic [15:0]           episode_count,
  output logic                  busy
);
  fsm_e                  state;
  logic [15:0]           lfsr;
  logic signed [Q_W-1:0] q_r [4];
  logic signed [Q_W-1:0] best;
  logic [7:0]            wait_cnt;
  logic [7:0]            eps;
  logic                  explore;
  logic [ACT_W-1:0]      greedy_act;
  logic [ACT_W-1:0]      sel_act;
  logic [STATE_W-1:0]    move_state;
  logic                  ep_end;
  logic [15:0]           count_inc;
  logic [15:0]           count_next;

`ifdef QLA_EPSILON_DECAY_EN
  logic [7:0] eps_q;
  assign eps = eps_q;
`else
  assign eps = EPSILON;
`endif

  assign busy = (state != ST_IDLE) && (state != ST_DONE);

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    greedy_act = 2'd0;
    best       = q_r[0];
    for (int i = 1; i < 4; i++) begin
      if (q_r[i] > best) begin
        best       = q_r[i];
        greedy_act = 2'(i);
      end
    end
  end

  assign explore    = lfsr[7:0] < eps;
  assign sel_act    = explore ? lfsr[9:8] : greedy_act;
  assign ep_end     = (next_state == GOAL_STATE) || (step == MAX_STEP);
  assign count_inc  = (episode_count == 16'hFFFF) ? episode_count : episode_count + 16'd1;
  assign count_next = ep_end ? count_inc : episode_count;

  qla_grid_step u_grid_step (
    .state      (current_state),
    .act        (sel_act),
    .next_state (move_state)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= LFSR_SEED;
    end else if (busy) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      current_state <= START_STATE;
      next_state    <= START_STATE;
      act           <= '0;
      step          <= '0;
      decoder_en    <= 1'b0;
      episode_done  <= 1'b0;
      episode_count <= '0;
      wait_cnt      <= '0;
      q_r           <= '{default: '0};
`ifdef QLA_EPSILON_DECAY_EN
      eps_q         <= EPSILON;
`endif
    end else begin
      decoder_en   <= 1'b0;
      episode_done <= 1'b0;
      case (state)
        ST_IDLE: if (start) state <= ST_FETCH;
        ST_FETCH: begin
          if (q_valid) begin
            q_r[0] <= q_in_0;
            q_r[1] <= q_in_1;
            q_r[2] <= q_in_2;
            q_r[3] <= q_in_3;
            state  <= ST_SELECT;
          end
        end
        // Move results are registered here so they are stable for the whole decoder_en cycle.
        ST_SELECT: begin
          act        <= sel_act;
          next_state <= move_state;
          step       <= step + 4'd1;
          decoder_en <= 1'b1;
          wait_cnt   <= '0;
          state      <= ST_MOVE;
        end
        ST_MOVE: state <= ST_WAIT;
        ST_WAIT: begin
          if (wait_cnt == 8'(UPDATE_LAT - 1)) state <= ST_ADVANCE;
          else wait_cnt <= wait_cnt + 8'd1;
        end
        ST_ADVANCE: begin
          if (ep_end) begin
            episode_done  <= 1'b1;
            episode_count <= count_inc;
            current_state <= START_STATE;
            step          <= '0;
`ifdef QLA_EPSILON_DECAY_EN
            if (eps_q != 8'd0) eps_q <= eps_q - 8'd1;
`endif
          end else begin
            current_state <= next_state;
          end
          state <= (count_next == NUM_EPISODES) ? ST_DONE : ST_FETCH;
        end
        ST_DONE: begin
          if (start) begin
            episode_count <= '0;
            step          <= '0;
`ifdef QLA_EPSILON_DECAY_EN
            eps_q         <= EPSILON;
`endif
            state         <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qla_episode_controller.sv
// Directed bench for qla_episode_controller: greedy ties, walls, goal, step limit, DONE restart, async reset.
module tb_qla_episode_controller;
  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               q_valid;
  logic signed [31:0] q_in_0, q_in_1, q_in_2, q_in_3;
  logic [4:0]         current_state, next_state;
  logic [1:0]         act;
  logic [3:0]         step;
  logic               decoder_en, episode_done, busy;
  logic [15:0]        episode_count;

  int total = 0;
  int bad   = 0;
  int lat;
  int n;

  always #5 clk = ~clk;

  qla_episode_controller #(
    .START_STATE(5'd1), .GOAL_STATE(5'd25), .MAX_STEP(4'd15), .EPSILON(8'd0),
    .NUM_EPISODES(16'd2), .UPDATE_LAT(2), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .q_valid(q_valid),
    .q_in_0(q_in_0), .q_in_1(q_in_1), .q_in_2(q_in_2), .q_in_3(q_in_3),
    .current_state(current_state), .next_state(next_state), .act(act), .step(step),
    .decoder_en(decoder_en), .episode_done(episode_done), .episode_count(episode_count),
    .busy(busy)
  );

`ifdef QLA_EPSILON_DECAY_EN
  logic        start2;
  logic [4:0]  e_cs, e_ns;
  logic [1:0]  e_act;
  logic [3:0]  e_step;
  logic        e_de, e_done, e_busy;
  logic [15:0] e_cnt;

  qla_episode_controller #(
    .EPSILON(8'd2), .NUM_EPISODES(16'd3)
  ) dut_eps (
    .clk(clk), .rst(rst), .start(start2), .q_valid(1'b1),
    .q_in_0(32'sd0), .q_in_1(32'sd0), .q_in_2(32'sd0), .q_in_3(32'sd0),
    .current_state(e_cs), .next_state(e_ns), .act(e_act), .step(e_step),
    .decoder_en(e_de), .episode_done(e_done), .episode_count(e_cnt), .busy(e_busy)
  );
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Presents one Q row, waits for the update strobe, checks the move, and returns in the next FETCH/DONE cycle.
  task automatic do_step(input int q0, input int q1, input int q2, input int q3,
                         input int exp_act, input int exp_ns, input int exp_step, output int latency);
    int k;
    k = 0;
    q_in_0 = q0; q_in_1 = q1; q_in_2 = q2; q_in_3 = q3;
    q_valid = 1'b1;
    while (!decoder_en && k < 20) begin
      @(negedge clk);
      k++;
    end
    latency = k;
    check("de_timeout", k < 20, 1);
    q_valid = 1'b0;
    check("act", act, exp_act);
    check("next_state", next_state, exp_ns);
    check("step", step, exp_step);
    @(negedge clk);
    check("de_one_cycle", decoder_en, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; q_valid = 1'b0;
    q_in_0 = 0; q_in_1 = 0; q_in_2 = 0; q_in_3 = 0;
`ifdef QLA_EPSILON_DECAY_EN
    start2 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_cs", current_state, 1);
    check("rst_ns", next_state, 1);
    check("rst_step", step, 0);
    check("rst_act", act, 0);
    check("rst_de", decoder_en, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt", episode_count, 0);
    check("rst_done", episode_done, 0);

    rst = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("fetch_busy", busy, 1);

    // Episode 1: tie, walk right into the east wall, then down to the goal.
    do_step(5, 10, -3, 10, 1, 2, 1, lat);
    check("fetch_to_de_lat", lat, 2);
    check("cs_after_1", current_state, 2);
    do_step(0, 9, 0, 0, 1, 3, 2, lat);
    do_step(0, 9, 0, 0, 1, 4, 3, lat);
    do_step(0, 9, 0, 0, 1, 5, 4, lat);
    do_step(0, 7, 7, -9, 1, 5, 5, lat);
    check("east_wall_cs", current_state, 5);
    check("east_wall_nodone", episode_done, 0);
    do_step(3, 1, 2, 0, 0, 10, 6, lat);
    do_step(3, 1, 2, 0, 0, 15, 7, lat);
    do_step(3, 1, 2, 0, 0, 20, 8, lat);
    do_step(3, 1, 2, 0, 0, 25, 9, lat);
    check("goal_done", episode_done, 1);
    check("goal_cs", current_state, 1);
    check("goal_step", step, 0);
    check("goal_cnt", episode_count, 1);
    check("goal_busy", busy, 1);
    @(negedge clk);
    check("goal_done_pulse", episode_done, 0);

    // Episode 2: all-negative Q always favours up from state 1; runs into the step limit.
    for (int k = 1; k <= 15; k++) begin
      do_step(-50, -20, -1, -30, 2, 1, k, lat);
      if (k == 14) begin
        check("limit_early_done", episode_done, 0);
        check("limit_early_cnt", episode_count, 1);
      end
    end
    check("limit_done", episode_done, 1);
    check("limit_cnt", episode_count, 2);
    check("limit_busy", busy, 0);
    check("limit_step", step, 0);
    check("limit_cs", current_state, 1);
    repeat (2) @(negedge clk);
    check("done_hold_busy", busy, 0);
    check("done_hold_cnt", episode_count, 2);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_cnt", episode_count, 0);
    check("restart_busy", busy, 1);

    // Abort while decoder_en is high.
    q_in_0 = 0; q_in_1 = 9; q_in_2 = 0; q_in_3 = 0;
    q_valid = 1'b1;
    n = 0;
    while (!decoder_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_de_seen", decoder_en, 1);
    rst = 1'b0;
    #1;
    check("abort_de", decoder_en, 0);
    check("abort_cs", current_state, 1);
    check("abort_ns", next_state, 1);
    check("abort_act", act, 0);
    check("abort_step", step, 0);
    check("abort_busy", busy, 0);
    check("abort_cnt", episode_count, 0);
    q_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

`ifdef QLA_EPSILON_DECAY_EN
    check("eps_reset", dut_eps.eps_q, 2);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int e = 0; e < 3; e++) begin
      n = 0;
      while (!e_done && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("eps_ep_timeout", n < 200, 1);
      check("eps_value", dut_eps.eps_q, (e < 2) ? (1 - e) : 0);
      @(negedge clk);
    end
    check("eps_done_busy", e_busy, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
